// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_pkg;

  // Fetch FSM: one settling cycle after reset, normal fetch, terminal halt.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Every instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Default program counter value after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory address/data plus the IF/ID register outputs.
// Latency: wires only; imem_rdata is a combinational read of imem_addr.
// Backpressure: none on the bus itself; stalls are applied inside the sequencer.
interface pc_fetch_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc4;
  logic              ifid_valid;

  // Sequencer side: drives the fetch address and the IF/ID contents.
  modport master (
    output imem_addr,
    input  imem_rdata,
    output ifid_instr,
    output ifid_pc4,
    output ifid_valid
  );

  // Memory/decode side: returns the instruction word and consumes IF/ID.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  ifid_instr,
    input  ifid_pc4,
    input  ifid_valid
  );

endinterface

// File: rtl/PCAdder.sv
// Sequential-PC incrementer: PC + one instruction width, wrapping modulo 2^ADDR_W.
// Latency: combinational.
// Backpressure: none.
module PCAdder
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc4_o
);

  // Carry out of the top bit is dropped, so 0xFFFF_FFFC rolls over to 0.
  assign pc4_o = pc_i + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// IF stage sequencer: owns the PC, picks next PC (branch > halt > stall > jump > PC+4), loads IF/ID.
// Latency: first instruction on IF/ID 2 edges after reset release; new PC visible 1 cycle after a redirect.
// Backpressure: stall_i holds PC, IF/ID and the fetch counter; halt freezes everything until reset.
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 jump_i,
  input  logic [ADDR_W-1:0]    jump_target_i,
  input  logic                 branch_taken_i,
  input  logic [ADDR_W-1:0]    branch_target_i,
  input  logic                 halt_i,
  output logic [ADDR_W-1:0]    pc_o,
  output logic                 flush_idex_o,
  output logic                 misalign_o,
  output logic [31:0]          fetch_count_o,
  pc_fetch_sequencer_if.master fetch_bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       count_q, count_d;
  logic [ADDR_W-1:0] pc_plus4;

  // Redirect targets are forced word-aligned; the dropped bits feed the sticky flag.
  logic [ADDR_W-1:0] branch_tgt_aligned;
  logic [ADDR_W-1:0] jump_tgt_aligned;
  logic              branch_tgt_odd;
  logic              jump_tgt_odd;

  assign branch_tgt_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign jump_tgt_aligned   = {jump_target_i[ADDR_W-1:2], 2'b00};
  assign branch_tgt_odd     = |branch_target_i[1:0];
  assign jump_tgt_odd       = |jump_target_i[1:0];

  PCAdder #(
    .ADDR_W (ADDR_W)
  ) u_pc_adder (
    .pc_i  (pc_q),
    .pc4_o (pc_plus4)
  );

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    misalign_d   = misalign_q;
    count_d      = count_q;
    flush_idex_o = 1'b0;

    case (state_q)
      INIT: begin
        // One settling cycle: PC held, nothing captured.
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken_i) begin
          // Resolved branch beats everything; squash both IF/ID and ID/EX.
          pc_d         = branch_tgt_aligned;
          valid_d      = 1'b0;
          flush_idex_o = 1'b1;
          misalign_d   = misalign_q | branch_tgt_odd;
        end else if (halt_i) begin
          // The in-flight sequential step retires the PC but nothing is captured.
          state_d = HALT;
          pc_d    = pc_plus4;
          valid_d = 1'b0;
        end else if (stall_i) begin
          // Hold everything; a jump in ID is seen again once the stall clears.
          state_d = RUN;
        end else if (jump_i) begin
          pc_d       = jump_tgt_aligned;
          valid_d    = 1'b0;
          misalign_d = misalign_q | jump_tgt_odd;
        end else begin
          instr_d = fetch_bus.imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          pc_d    = pc_plus4;
        end
      end
      HALT: begin
        // Terminal until reset: nothing moves, IF/ID stays empty.
        valid_d = 1'b0;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc_o                 = pc_q;
  assign fetch_bus.imem_addr  = pc_q;
  assign fetch_bus.ifid_instr = instr_q;
  assign fetch_bus.ifid_pc4   = pc4_q;
  assign fetch_bus.ifid_valid = valid_q;
  assign misalign_o           = misalign_q;
  assign fetch_count_o        = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed vectors, behavioural model, per-cycle compare.
// Latency: model is updated at each rising edge, outputs compared on the falling edge.
// Backpressure: stall/halt/redirect scenarios are driven directly.
module tb_pc_fetch_sequencer;
  import pc_pkg::*;

  localparam int          AW       = 32;
  localparam logic [31:0] TAG      = 32'hDEAD_BEEF;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          jump;
  logic [AW-1:0] jump_tgt;
  logic          branch;
  logic [AW-1:0] branch_tgt;
  logic          halt;
  logic [AW-1:0] pc;
  logic          flush;
  logic          misalign;
  logic [31:0]   count;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.ADDR_W(AW)) bus ();

  // Memory returns a word derived from its address so fetched data is traceable.
  assign bus.imem_rdata = bus.imem_addr ^ TAG;

  pc_fetch_sequencer #(
    .ADDR_W   (AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .jump_i          (jump),
    .jump_target_i   (jump_tgt),
    .branch_taken_i  (branch),
    .branch_target_i (branch_tgt),
    .halt_i          (halt),
    .pc_o            (pc),
    .flush_idex_o    (flush),
    .misalign_o      (misalign),
    .fetch_count_o   (count),
    .fetch_bus       (bus.master)
  );

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  bit          m_valid, m_mis, m_init, m_halt;
  bit          check_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt, input bit h);
    rst        = r;
    stall      = s;
    jump       = j;
    jump_tgt   = jt;
    branch     = b;
    branch_tgt = bt;
    halt       = h;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance one clock; the model applies the rules to the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_init = 1'b1; m_halt = 1'b0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (branch) begin
      m_mis   = m_mis | (branch_tgt[1:0] != 2'b00);
      m_pc    = branch_tgt & ~32'h3;
      m_valid = 1'b0;
    end else if (halt) begin
      m_halt  = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (jump) begin
      m_mis   = m_mis | (jump_tgt[1:0] != 2'b00);
      m_pc    = jump_tgt & ~32'h3;
      m_valid = 1'b0;
    end else begin
      m_instr = m_pc ^ TAG;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, m_valid});
      if (m_valid) begin
        chk("ifid_instr", bus.ifid_instr, m_instr);
        chk("ifid_pc4", bus.ifid_pc4, m_pc4);
      end
      chk("fetch_count", count, m_cnt);
      chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
      chk("flush_idex", {31'h0, flush}, {31'h0, (!m_init && !m_halt && branch)});
    end
  end

  initial begin
    // Reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check_en = 1'b1;
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'h0, bus.ifid_valid}, 32'h0);
    chk("reset_count", count, 32'h0);
    chk("reset_misalign", {31'h0, misalign}, 32'h0);

    // INIT cycle holds the PC, then free run.
    idle();
    tick();
    chk("init_pc", pc, 32'h0);
    chk("init_valid", {31'h0, bus.ifid_valid}, 32'h0);
    tick();
    chk("first_pc4", bus.ifid_pc4, 32'h4);
    chk("first_instr", bus.ifid_instr, 32'hDEAD_BEEF);
    chk("first_count", count, 32'd1);
    tick();
    chk("second_pc4", bus.ifid_pc4, 32'h8);
    tick();
    chk("third_pc4", bus.ifid_pc4, 32'hC);
    chk("third_count", count, 32'd3);
    repeat (5) tick();
    chk("at_0x20", pc, 32'h20);

    // Branch together with stall: branch wins, flush in the same cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    #1;
    chk("branch_flush", {31'h0, flush}, 32'h1);
    tick();
    chk("branch_pc", pc, 32'h100);
    chk("branch_valid", {31'h0, bus.ifid_valid}, 32'h0);
    chk("branch_count", count, 32'd8);

    // Jump during stall is held off, then taken.
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("stall_jump_hold", pc, 32'h100);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    tick();
    chk("jump_pc", pc, 32'h40);
    chk("jump_bubble", {31'h0, bus.ifid_valid}, 32'h0);
    idle();
    tick();
    chk("jump_fetch_pc4", bus.ifid_pc4, 32'h44);
    chk("jump_fetch_count", count, 32'd9);
    chk("misalign_clear", {31'h0, misalign}, 32'h0);

    // Misaligned jump target.
    drive(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0, 1'b0);
    tick();
    chk("misalign_pc", pc, 32'h40);
    chk("misalign_set", {31'h0, misalign}, 32'h1);
    idle();
    repeat (3) tick();
    chk("misalign_sticky", {31'h0, misalign}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();

    // Wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    tick();
    chk("wrap_start_pc", pc, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    chk("wrap_valid", {31'h0, bus.ifid_valid}, 32'h1);
    chk("wrap_count", count, 32'd13);

    // Halt at PC 0x10.
    repeat (4) tick();
    chk("pre_halt_pc", pc, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("halt_pc", pc, 32'h14);
    chk("halt_valid", {31'h0, bus.ifid_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    #1;
    chk("halt_no_flush", {31'h0, flush}, 32'h0);
    repeat (3) tick();
    chk("halt_frozen_pc", pc, 32'h14);
    chk("halt_frozen_count", count, 32'd17);

    // Reset mid-halt with redirects pending: reset wins.
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", count, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    tick();
    chk("reinit_pc", pc, 32'h0);
    tick();
    chk("post_init_jump_pc", pc, 32'h80);

    // Misaligned branch target.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h106, 1'b0);
    tick();
    chk("branch_mis_pc", pc, 32'h104);
    chk("branch_mis_flag", {31'h0, misalign}, 32'h1);
    idle();
    repeat (2) tick();

    check_en = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
